// File: rtl/seg_display_arbiter.sv
// Priority arbiter sharing the 8-digit seven-segment driver between a background
// source and two requesters, with minimum hold time and per-source blinking.
module seg_display_arbiter #(
  parameter int unsigned HOLD_TICKS  = 8000,
  parameter int unsigned BLINK_TICKS = 4000,
  parameter int unsigned CNT_W       = 16,
  parameter logic [7:0]  BLANK       = 8'hFF
) (
  input  logic        clk_out,
  input  logic        reset,
  input  logic        req1,
  input  logic        req2,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  input  logic [2:0]  blink,
  output logic [7:0]  display0,
  output logic [7:0]  display1,
  output logic [7:0]  display2,
  output logic [7:0]  display3,
  output logic [7:0]  display4,
  output logic [7:0]  display5,
  output logic [7:0]  display6,
  output logic [7:0]  display7,
  output logic [2:0]  grant,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {S_BG, S_HOLD, S_OWN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic               sp_q, sp_d;
  logic [63:0]        disp_q, disp_d;

  logic               own2, own_req, oth_req, evaluate, switching, blank_now;
  logic [63:0]        sel_frame;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    evaluate = 1'b0;
    own2     = grant_q[2];
    own_req  = own2 ? req2 : req1;
    oth_req  = own2 ? req1 : req2;

    case (state_q)
      S_BG: begin
        if (req2) begin
          state_d = S_HOLD;
          grant_d = 3'b100;
          hold_d  = CNT_W'(HOLD_TICKS - 1);
        end else if (req1) begin
          state_d = S_HOLD;
          grant_d = 3'b010;
          hold_d  = CNT_W'(HOLD_TICKS - 1);
        end
      end
      S_HOLD: begin
        if (hold_q != '0) hold_d = hold_q - CNT_W'(1);
        else              evaluate = 1'b1;
      end
      S_OWN:   evaluate = 1'b1;
      default: begin
        state_d = S_BG;
        grant_d = 3'b001;
      end
    endcase

    // Hold expiry edge doubles as the first ownership evaluation, so a source
    // whose request already dropped keeps the grant for exactly HOLD_TICKS cycles.
    if (evaluate) begin
      if (!own2 && req2) begin
        state_d = S_HOLD;
        grant_d = 3'b100;
        hold_d  = CNT_W'(HOLD_TICKS - 1);
      end else if (!own_req && oth_req) begin
        state_d = S_HOLD;
        grant_d = own2 ? 3'b010 : 3'b100;
        hold_d  = CNT_W'(HOLD_TICKS - 1);
      end else if (!own_req) begin
        state_d = S_BG;
        grant_d = 3'b001;
      end else begin
        state_d = S_OWN;
      end
    end
  end

  always_comb begin
    switching = (grant_d != grant_q);
    sp_d      = switching;
    bcnt_d    = bcnt_q + CNT_W'(1);
    phase_d   = phase_q;
    if (switching) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == CNT_W'(BLINK_TICKS - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end

    case (grant_q)
      3'b100:  sel_frame = frame2;
      3'b010:  sel_frame = frame1;
      default: sel_frame = frame0;
    endcase
    blank_now = (|(blink & grant_q)) && phase_q;
    disp_d    = blank_now ? {8{BLANK}} : sel_frame;
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q <= S_BG;
      grant_q <= 3'b001;
      hold_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      sp_q    <= 1'b0;
      disp_q  <= {8{BLANK}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      sp_q    <= sp_d;
      disp_q  <= disp_d;
    end
  end

  assign grant        = grant_q;
  assign switch_pulse = sp_q;
  assign display0     = disp_q[7:0];
  assign display1     = disp_q[15:8];
  assign display2     = disp_q[23:16];
  assign display3     = disp_q[31:24];
  assign display4     = disp_q[39:32];
  assign display5     = disp_q[47:40];
  assign display6     = disp_q[55:48];
  assign display7     = disp_q[63:56];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares after each edge.
module tb_seg_display_arbiter;

  localparam logic [63:0] F0 = 64'h0011223344556677;
  localparam logic [63:0] F1 = 64'h8899AABBCCDDEEF0;
  localparam logic [63:0] F2 = 64'h0123456789ABCDEF;
  localparam int unsigned BL = 3;

  logic        clk_out, reset, req1, req2;
  logic [63:0] frame0, frame1, frame2;
  logic [2:0]  blink, grant;
  logic [7:0]  display0, display1, display2, display3;
  logic [7:0]  display4, display5, display6, display7;
  logic        switch_pulse;
  logic        done;

  typedef struct {
    logic [2:0]  g;
    logic        sp;
    int unsigned d;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  seg_display_arbiter #(.HOLD_TICKS(4), .BLINK_TICKS(3)) dut (
    .clk_out(clk_out), .reset(reset), .req1(req1), .req2(req2),
    .frame0(frame0), .frame1(frame1), .frame2(frame2), .blink(blink),
    .display0(display0), .display1(display1), .display2(display2),
    .display3(display3), .display4(display4), .display5(display5),
    .display6(display6), .display7(display7),
    .grant(grant), .switch_pulse(switch_pulse)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  function automatic logic [63:0] expf(input int unsigned d);
    case (d)
      0:       return F0;
      1:       return F1;
      2:       return F2;
      default: return {8{8'hFF}};
    endcase
  endfunction

  task automatic push(input logic [2:0] g, input logic sp, input int unsigned d,
                      input string nm);
    exp_t e;
    e.g = g; e.sp = sp; e.d = d; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic r1, input logic r2, input logic [2:0] bl,
                      input logic [2:0] g, input logic sp, input int unsigned d,
                      input string nm);
    req1 = r1; req2 = r2; blink = bl;
    push(g, sp, d, nm);
    @(negedge clk_out);
  endtask

  // Monitor: samples 1 time unit after each rising edge or reset assertion.
  initial begin
    exp_t        e;
    logic [63:0] disp;
    forever begin
      @(posedge clk_out or negedge reset);
      #1;
      if (q.size() > 0) begin
        e    = q.pop_front();
        disp = {display7, display6, display5, display4,
                display3, display2, display1, display0};
        checks++;
        if (grant !== e.g) begin
          errors++;
          $display("FAIL %s grant: got %b expected %b", e.name, grant, e.g);
        end
        checks++;
        if (switch_pulse !== e.sp) begin
          errors++;
          $display("FAIL %s switch_pulse: got %b expected %b", e.name, switch_pulse, e.sp);
        end
        checks++;
        if (disp !== expf(e.d)) begin
          errors++;
          $display("FAIL %s display: got %h expected %h", e.name, disp, expf(e.d));
        end
      end else if (done) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    done = 1'b0;
    reset = 1'b0; req1 = 1'b0; req2 = 1'b0; blink = 3'b000;
    frame0 = F0; frame1 = F1; frame2 = F2;
    repeat (2) @(negedge clk_out);
    step(0, 0, 3'b000, 3'b001, 0, BL, "reset_state");
    reset = 1'b1;

    // 1: background frame after reset
    repeat (2) step(0, 0, 3'b000, 3'b001, 0, 0, "t1_frame0");

    // 2: one-cycle req1 pulse holds grant exactly 4 cycles
    step(1, 0, 3'b000, 3'b010, 1, 0, "t2_grant");
    repeat (3) step(0, 0, 3'b000, 3'b010, 0, 1, "t2_hold");
    step(0, 0, 3'b000, 3'b001, 1, 1, "t2_release");
    step(0, 0, 3'b000, 3'b001, 0, 0, "t2_bg");

    // 3: owner 1 preempted by req2, then returns to owner 1
    step(1, 0, 3'b000, 3'b010, 1, 0, "t3_grant1");
    repeat (3) step(1, 0, 3'b000, 3'b010, 0, 1, "t3_hold1");
    repeat (2) step(1, 0, 3'b000, 3'b010, 0, 1, "t3_own1");
    step(1, 1, 3'b000, 3'b100, 1, 1, "t3_preempt");
    repeat (3) step(1, 1, 3'b000, 3'b100, 0, 2, "t3_hold2");
    step(1, 1, 3'b000, 3'b100, 0, 2, "t3_own2");
    step(1, 0, 3'b000, 3'b010, 1, 2, "t3_return1");

    // 4: source 1 never preempts owner 2
    repeat (3) step(1, 0, 3'b000, 3'b010, 0, 1, "t4_hold1");
    step(1, 0, 3'b000, 3'b010, 0, 1, "t4_own1");
    step(1, 1, 3'b000, 3'b100, 1, 1, "t4_preempt");
    repeat (3) step(1, 1, 3'b000, 3'b100, 0, 2, "t4_hold2");
    repeat (3) step(1, 1, 3'b000, 3'b100, 0, 2, "t4_stay2");
    step(1, 0, 3'b000, 3'b010, 1, 2, "t4_drop2");
    repeat (3) step(0, 0, 3'b000, 3'b010, 0, 1, "t4_hold_noreq");
    step(0, 0, 3'b000, 3'b001, 1, 1, "t4_release");
    step(0, 0, 3'b000, 3'b001, 0, 0, "t4_bg");

    // 5: simultaneous requests from background go to source 2
    step(1, 1, 3'b000, 3'b100, 1, 0, "t5_both");
    step(1, 1, 3'b000, 3'b100, 0, 2, "t5_hold");
    repeat (2) step(0, 0, 3'b000, 3'b100, 0, 2, "t5_hold_noreq");
    step(0, 0, 3'b000, 3'b001, 1, 2, "t5_release");
    step(0, 0, 3'b000, 3'b001, 0, 0, "t5_bg");

    // 6: blinking owner 1, blink disable, async reset mid-blink
    step(1, 0, 3'b010, 3'b010, 1, 0, "t6_grant");
    repeat (3) step(1, 0, 3'b010, 3'b010, 0, 1, "t6_vis_a");
    repeat (3) step(1, 0, 3'b010, 3'b010, 0, BL, "t6_blank_a");
    repeat (3) step(1, 0, 3'b010, 3'b010, 0, 1, "t6_vis_b");
    step(1, 0, 3'b010, 3'b010, 0, BL, "t6_blank_b");
    step(1, 0, 3'b000, 3'b010, 0, 1, "t6_blink_off");
    step(1, 0, 3'b010, 3'b010, 0, BL, "t6_blink_on");
    #2;
    push(3'b001, 0, BL, "t6_reset_async");
    reset = 1'b0;
    @(negedge clk_out);
    step(0, 0, 3'b000, 3'b001, 0, BL, "t6_reset_held");
    reset = 1'b1;
    step(0, 0, 3'b000, 3'b001, 0, 0, "t6_after_reset");
    done = 1'b1;
  end

endmodule
